// File: rtl/ts_output_scheduler_pkg.sv
// Shared encodings, constants and helpers for the TS output scheduler.
package ts_output_scheduler_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned TS_PKT_LEN = 188;

    localparam logic [BYTE_W-1:0] TS_SYNC_BYTE = 8'h47;
    localparam logic [12:0]       NULL_PID     = 13'h1FFF;
    localparam logic [12:0]       PAT_PID      = 13'h0000;
    localparam logic [12:0]       SDT_PID      = 13'h0011;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_TAB  = 3'd1,
        S_T2MI = 3'd2,
        S_GAP  = 3'd3,
        S_NULL = 3'd4
    } sched_state_t;

    // One TS byte lane as it travels from a source to the output register.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              ena;
        logic              psync;
    } ts_byte_t;

    // Byte idx of a null packet: header 47 1F FF 10 (PID 0x1FFF, payload only), then stuffing.
    function automatic logic [BYTE_W-1:0] null_pkt_byte(input logic [BYTE_W-1:0] idx);
        case (idx)
            8'd0:    return TS_SYNC_BYTE;
            8'd1:    return {3'b000, NULL_PID[12:8]};
            8'd2:    return NULL_PID[7:0];
            8'd3:    return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ts_output_scheduler_null_packet_gen.sv
// Null packet generator: after a start pulse emits one PKT_LEN-byte null packet,
// one byte per cycle, then pulses done. Only instantiated with TS_NULL_PACKET_EN.
module ts_null_packet_gen
    import ts_output_scheduler_pkg::*;
#(
    parameter int unsigned PKT_LEN = TS_PKT_LEN
) (
    input  logic              RST,
    input  logic              CLK,
    input  logic              start,
    output logic [BYTE_W-1:0] data,
    output logic              ena,
    output logic              psync,
    output logic              done
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] byte_cnt;
    logic             active;

    // Walk the packet bytes; byte_cnt is the index of the next byte to emit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            active   <= 1'b0;
            byte_cnt <= '0;
            data     <= '0;
            ena      <= 1'b0;
            psync    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done  <= 1'b0;
            psync <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                byte_cnt <= CNT_W'(1);
                data     <= null_pkt_byte(8'd0);
                ena      <= 1'b1;
                psync    <= 1'b1;
            end else if (active) begin
                if (byte_cnt == CNT_W'(PKT_LEN)) begin
                    active <= 1'b0;
                    ena    <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    data     <= null_pkt_byte(byte_cnt);
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ts_output_scheduler.sv
// TS output scheduler: packet-boundary arbitration between the T2-MI packetizer
// and the PSI table inserter, with table-burst fairness and a stall watchdog.
// Optional idle null-packet insertion is enabled by defining TS_NULL_PACKET_EN.
module ts_output_scheduler
    import ts_output_scheduler_pkg::*;
#(
    parameter int unsigned PKT_LEN       = TS_PKT_LEN,
    parameter int unsigned MAX_TAB_BURST = 2,
`ifdef TS_NULL_PACKET_EN
    parameter int unsigned NULL_TIMEOUT  = 1024,
`endif
    parameter int unsigned WDOG_CYCLES   = 4096
) (
    input  logic               RST,
    input  logic               CLK,
    input  logic               T2MI_REQ,
    output logic               T2MI_GRANT,
    input  logic [BYTE_W-1:0]  T2MI_DATA,
    input  logic               T2MI_ENA,
    input  logic               T2MI_PSYNC,
    input  logic               TABLE_READY,
    output logic               TABLE_START,
    input  logic               TABLE_SENT,
    input  logic [BYTE_W-1:0]  TAB_DATA,
    input  logic               TAB_ENA,
    input  logic               TAB_PSYNC,
    output logic [BYTE_W-1:0]  DATA_OUT,
    output logic               ENA_OUT,
    output logic               PSYNC_OUT,
    output logic               ERR_WDOG,
    output logic               ERR_SYNC,
    output logic [STATE_W-1:0] state_mon
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BURST_W = $clog2(MAX_TAB_BURST + 1);
    localparam int unsigned WDOG_W  = $clog2(WDOG_CYCLES + 1);

    sched_state_t       state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [BURST_W-1:0] tab_burst;
    logic [WDOG_W-1:0]  wdog;

    ts_byte_t t2mi_lane_c;
    ts_byte_t tab_lane_c;
    logic     sel_ena_c;
    logic     wdog_expire_c;
    logic     table_win_c;

    assign t2mi_lane_c = '{data: T2MI_DATA, ena: T2MI_ENA, psync: T2MI_PSYNC};
    assign tab_lane_c  = '{data: TAB_DATA,  ena: TAB_ENA,  psync: TAB_PSYNC};
    assign state_mon   = state;

    // Tables win unless they have already taken MAX_TAB_BURST packets while T2-MI waits.
    assign table_win_c = TABLE_READY &&
                         ((tab_burst < BURST_W'(MAX_TAB_BURST)) || !T2MI_REQ);

    // Valid strobe of whichever source currently owns the output.
    always_comb begin
        sel_ena_c = 1'b0;
        case (state)
            S_TAB:   sel_ena_c = tab_lane_c.ena;
            S_T2MI:  sel_ena_c = t2mi_lane_c.ena;
            default: sel_ena_c = 1'b0;
        endcase
    end

    assign wdog_expire_c = ((state == S_TAB) || (state == S_T2MI)) && !sel_ena_c &&
                           (wdog == WDOG_W'(WDOG_CYCLES - 1));

    // Stall watchdog: counts consecutive idle cycles of the granted source.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wdog <= '0;
        end else if (((state == S_TAB) || (state == S_T2MI)) && !sel_ena_c && !wdog_expire_c) begin
            wdog <= wdog + WDOG_W'(1);
        end else begin
            wdog <= '0;
        end
    end

`ifdef TS_NULL_PACKET_EN
    localparam int unsigned IDLE_W = $clog2(NULL_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              null_start;
    logic [BYTE_W-1:0] null_data;
    logic              null_ena;
    logic              null_psync;
    logic              null_done;

    ts_null_packet_gen #(
        .PKT_LEN (PKT_LEN)
    ) u_null_gen (
        .RST   (RST),
        .CLK   (CLK),
        .start (null_start),
        .data  (null_data),
        .ena   (null_ena),
        .psync (null_psync),
        .done  (null_done)
    );
`endif

    // Scheduler FSM with registered output mux.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            T2MI_GRANT  <= 1'b0;
            TABLE_START <= 1'b0;
            DATA_OUT    <= '0;
            ENA_OUT     <= 1'b0;
            PSYNC_OUT   <= 1'b0;
            ERR_WDOG    <= 1'b0;
            ERR_SYNC    <= 1'b0;
            byte_cnt    <= '0;
            tab_burst   <= '0;
`ifdef TS_NULL_PACKET_EN
            idle_cnt    <= '0;
            null_start  <= 1'b0;
`endif
        end else begin
            TABLE_START <= 1'b0;
            ERR_WDOG    <= 1'b0;
            ERR_SYNC    <= 1'b0;
`ifdef TS_NULL_PACKET_EN
            null_start  <= 1'b0;
            idle_cnt    <= '0;
`endif
            case (state)
                S_IDLE: begin
                    ENA_OUT   <= 1'b0;
                    PSYNC_OUT <= 1'b0;
                    if (table_win_c) begin
                        state       <= S_TAB;
                        TABLE_START <= 1'b1;
                        if (tab_burst != BURST_W'(MAX_TAB_BURST)) begin
                            tab_burst <= tab_burst + BURST_W'(1);
                        end
                    end else if (T2MI_REQ) begin
                        state      <= S_T2MI;
                        T2MI_GRANT <= 1'b1;
                        tab_burst  <= '0;
                        byte_cnt   <= '0;
                    end
`ifdef TS_NULL_PACKET_EN
                    else if (idle_cnt == IDLE_W'(NULL_TIMEOUT - 1)) begin
                        state      <= S_NULL;
                        null_start <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
`endif
                end
                S_TAB: begin
                    DATA_OUT  <= tab_lane_c.data;
                    ENA_OUT   <= tab_lane_c.ena;
                    PSYNC_OUT <= tab_lane_c.psync;
                    if (TABLE_SENT) begin
                        state <= S_GAP;
                    end else if (wdog_expire_c) begin
                        ERR_WDOG   <= 1'b1;
                        T2MI_GRANT <= 1'b0;
                        tab_burst  <= '0;
                        state      <= S_GAP;
                    end
                end
                S_T2MI: begin
                    DATA_OUT  <= t2mi_lane_c.data;
                    ENA_OUT   <= t2mi_lane_c.ena;
                    PSYNC_OUT <= t2mi_lane_c.psync;
                    if (t2mi_lane_c.ena) begin
                        if (t2mi_lane_c.psync && (byte_cnt != '0)) begin
                            // Misplaced sync: realign so this byte is byte 1 of the packet.
                            ERR_SYNC <= 1'b1;
                            byte_cnt <= CNT_W'(1);
                        end else if (byte_cnt == CNT_W'(PKT_LEN - 1)) begin
                            byte_cnt   <= CNT_W'(PKT_LEN);
                            T2MI_GRANT <= 1'b0;
                            state      <= S_GAP;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else if (wdog_expire_c) begin
                        ERR_WDOG   <= 1'b1;
                        T2MI_GRANT <= 1'b0;
                        tab_burst  <= '0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    // One dead cycle lets the inserter drop READY before re-arbitration.
                    ENA_OUT   <= 1'b0;
                    PSYNC_OUT <= 1'b0;
                    state     <= S_IDLE;
                end
`ifdef TS_NULL_PACKET_EN
                S_NULL: begin
                    DATA_OUT  <= null_data;
                    ENA_OUT   <= null_ena;
                    PSYNC_OUT <= null_psync;
                    if (null_done) begin
                        state <= S_GAP;
                    end
                end
`endif
                default: begin
                    ENA_OUT   <= 1'b0;
                    PSYNC_OUT <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ts_output_scheduler.sv
// Directed bench for ts_output_scheduler (null-packet checks only with TS_NULL_PACKET_EN).
module tb_ts_output_scheduler;
    import ts_output_scheduler_pkg::*;

    logic        RST, CLK;
    logic        T2MI_REQ, T2MI_GRANT, T2MI_ENA, T2MI_PSYNC;
    logic [7:0]  T2MI_DATA;
    logic        TABLE_READY, TABLE_START, TABLE_SENT, TAB_ENA, TAB_PSYNC;
    logic [7:0]  TAB_DATA;
    logic [7:0]  DATA_OUT;
    logic        ENA_OUT, PSYNC_OUT, ERR_WDOG, ERR_SYNC;
    logic [2:0]  state_mon;

    int n_vec = 0;
    int n_err = 0;

    ts_output_scheduler dut (
        .RST(RST), .CLK(CLK),
        .T2MI_REQ(T2MI_REQ), .T2MI_GRANT(T2MI_GRANT), .T2MI_DATA(T2MI_DATA),
        .T2MI_ENA(T2MI_ENA), .T2MI_PSYNC(T2MI_PSYNC),
        .TABLE_READY(TABLE_READY), .TABLE_START(TABLE_START), .TABLE_SENT(TABLE_SENT),
        .TAB_DATA(TAB_DATA), .TAB_ENA(TAB_ENA), .TAB_PSYNC(TAB_PSYNC),
        .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC_OUT(PSYNC_OUT),
        .ERR_WDOG(ERR_WDOG), .ERR_SYNC(ERR_SYNC), .state_mon(state_mon)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        T2MI_REQ = 0; T2MI_DATA = 0; T2MI_ENA = 0; T2MI_PSYNC = 0;
        TABLE_READY = 0; TABLE_SENT = 0; TAB_DATA = 0; TAB_ENA = 0; TAB_PSYNC = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 0;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if ({DATA_OUT, ENA_OUT, PSYNC_OUT, T2MI_GRANT, TABLE_START, ERR_WDOG, ERR_SYNC} !== 15'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0",
                {DATA_OUT, ENA_OUT, PSYNC_OUT, T2MI_GRANT, TABLE_START, ERR_WDOG, ERR_SYNC});
        end
        n_vec++;
        if (state_mon !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_mon); end
        RST = 1;
        tick();
        n_vec++;
        if (state_mon !== 3'd0) begin n_err++; $display("FAIL post_reset_idle got %0d want 0", state_mon); end
    endtask

    task automatic test_table();
        logic [7:0] tb_bytes [4];
        tb_bytes[0] = 8'h47; tb_bytes[1] = 8'h40; tb_bytes[2] = 8'h00; tb_bytes[3] = 8'h10;
        TABLE_READY = 1;
        tick();
        n_vec++;
        if (TABLE_START !== 1'b1 || state_mon !== 3'd1) begin
            n_err++; $display("FAIL tab_start got start=%0b st=%0d want 1/1", TABLE_START, state_mon);
        end
        TABLE_READY = 0;
        for (int i = 0; i < 4; i++) begin
            TAB_DATA = tb_bytes[i]; TAB_ENA = 1; TAB_PSYNC = (i == 0); TABLE_SENT = (i == 3);
            tick();
            n_vec++;
            if (DATA_OUT !== tb_bytes[i] || ENA_OUT !== 1'b1 || PSYNC_OUT !== (i == 0)) begin
                n_err++; $display("FAIL tab_byte%0d got %h/%0b/%0b want %h/1/%0b",
                    i, DATA_OUT, ENA_OUT, PSYNC_OUT, tb_bytes[i], (i == 0));
            end
            if (i == 0) begin
                n_vec++;
                if (TABLE_START !== 1'b0) begin n_err++; $display("FAIL tab_start_pulse got 1 want 0"); end
            end
        end
        n_vec++;
        if (state_mon !== 3'd3) begin n_err++; $display("FAIL tab_gap got %0d want 3", state_mon); end
        TAB_ENA = 0; TAB_PSYNC = 0; TABLE_SENT = 0;
        tick();
        n_vec++;
        if (state_mon !== 3'd0 || ENA_OUT !== 1'b0) begin
            n_err++; $display("FAIL tab_after_gap got st=%0d ena=%0b want 0/0", state_mon, ENA_OUT);
        end
    endtask

    task automatic test_ungranted();
        T2MI_DATA = 8'hA5; T2MI_ENA = 1; T2MI_PSYNC = 1;
        TAB_DATA = 8'h5A; TAB_ENA = 1; TAB_PSYNC = 1;
        repeat (2) tick();
        n_vec++;
        if (ENA_OUT !== 1'b0 || PSYNC_OUT !== 1'b0 || T2MI_GRANT !== 1'b0 || state_mon !== 3'd0) begin
            n_err++; $display("FAIL ungranted got ena=%0b ps=%0b gr=%0b st=%0d want 0/0/0/0",
                ENA_OUT, PSYNC_OUT, T2MI_GRANT, state_mon);
        end
        n_vec++;
        if (DATA_OUT !== 8'h10) begin n_err++; $display("FAIL data_hold got %h want 10", DATA_OUT); end
        idle_inputs();
    endtask

    task automatic test_t2mi_packet();
        logic [7:0] exp_b;
        T2MI_REQ = 1;
        tick();
        n_vec++;
        if (T2MI_GRANT !== 1'b1 || state_mon !== 3'd2) begin
            n_err++; $display("FAIL t2mi_grant got gr=%0b st=%0d want 1/2", T2MI_GRANT, state_mon);
        end
        T2MI_REQ = 0;
        for (int i = 0; i < 188; i++) begin
            exp_b = (i == 0) ? 8'h47 : 8'(i);
            T2MI_DATA = exp_b; T2MI_ENA = 1; T2MI_PSYNC = (i == 0);
            tick();
            n_vec++;
            if (DATA_OUT !== exp_b || ENA_OUT !== 1'b1 || T2MI_GRANT !== (i != 187)) begin
                n_err++; $display("FAIL t2mi_byte%0d got %h/%0b gr=%0b want %h/1 gr=%0b",
                    i, DATA_OUT, ENA_OUT, T2MI_GRANT, exp_b, (i != 187));
            end
        end
        T2MI_ENA = 0; T2MI_PSYNC = 0;
        n_vec++;
        if (state_mon !== 3'd3) begin n_err++; $display("FAIL t2mi_gap got %0d want 3", state_mon); end
        tick();
        n_vec++;
        if (state_mon !== 3'd0 || ENA_OUT !== 1'b0) begin
            n_err++; $display("FAIL t2mi_idle got st=%0d ena=%0b want 0/0", state_mon, ENA_OUT);
        end
    endtask

    task automatic test_sync_error();
        T2MI_REQ = 1;
        tick();
        T2MI_REQ = 0;
        for (int i = 0; i < 100; i++) begin
            T2MI_DATA = (i == 0 || i == 99) ? 8'h47 : 8'(i + 32); T2MI_ENA = 1;
            T2MI_PSYNC = (i == 0 || i == 99);
            tick();
            if (i == 98) begin
                n_vec++;
                if (ERR_SYNC !== 1'b0) begin n_err++; $display("FAIL sync_early got 1 want 0"); end
            end
        end
        n_vec++;
        if (ERR_SYNC !== 1'b1 || PSYNC_OUT !== 1'b1) begin
            n_err++; $display("FAIL sync_pulse got err=%0b ps=%0b want 1/1", ERR_SYNC, PSYNC_OUT);
        end
        T2MI_PSYNC = 0;
        for (int j = 0; j < 187; j++) begin
            T2MI_DATA = 8'(j); T2MI_ENA = 1;
            tick();
            if (j == 0) begin
                n_vec++;
                if (ERR_SYNC !== 1'b0) begin n_err++; $display("FAIL sync_pulse_len got 1 want 0"); end
            end
            if (j == 185) begin
                n_vec++;
                if (T2MI_GRANT !== 1'b1) begin n_err++; $display("FAIL sync_grant_hold got 0 want 1"); end
            end
        end
        n_vec++;
        if (T2MI_GRANT !== 1'b0 || state_mon !== 3'd3) begin
            n_err++; $display("FAIL sync_realign_end got gr=%0b st=%0d want 0/3", T2MI_GRANT, state_mon);
        end
        T2MI_ENA = 0;
        tick();
    endtask

    task automatic test_watchdog();
        int n;
        T2MI_REQ = 1;
        tick();
        T2MI_REQ = 0;
        for (int i = 0; i < 50; i++) begin
            T2MI_DATA = 8'(i); T2MI_ENA = 1; T2MI_PSYNC = (i == 0);
            tick();
        end
        T2MI_ENA = 0; T2MI_PSYNC = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (ERR_WDOG !== 1'b1 && n < 5000);
        n_vec++;
        if (n !== 4096) begin n_err++; $display("FAIL wdog_cycles got %0d want 4096", n); end
        n_vec++;
        if (T2MI_GRANT !== 1'b0 || state_mon !== 3'd3) begin
            n_err++; $display("FAIL wdog_abort got gr=%0b st=%0d want 0/3", T2MI_GRANT, state_mon);
        end
        tick();
        n_vec++;
        if (ERR_WDOG !== 1'b0 || state_mon !== 3'd0) begin
            n_err++; $display("FAIL wdog_recover got err=%0b st=%0d want 0/0", ERR_WDOG, state_mon);
        end
    endtask

    task automatic test_fairness();
        int waited;
        int got;
        int want;
        TABLE_READY = 1; T2MI_REQ = 1;
        for (int k = 0; k < 6; k++) begin
            want = (k % 3 == 2) ? 2 : 1;
            waited = 0;
            got = 0;
            while (got == 0 && waited < 50) begin
                tick();
                waited++;
                if (TABLE_START === 1'b1) got = 1;
                else if (T2MI_GRANT === 1'b1) got = 2;
            end
            n_vec++;
            if (got !== want) begin n_err++; $display("FAIL fair_grant%0d got %0d want %0d", k, got, want); end
            if (got == 1) begin
                for (int i = 0; i < 4; i++) begin
                    TAB_DATA = 8'(i); TAB_ENA = 1; TAB_PSYNC = (i == 0); TABLE_SENT = (i == 3);
                    tick();
                end
                TAB_ENA = 0; TAB_PSYNC = 0; TABLE_SENT = 0;
            end else if (got == 2) begin
                for (int i = 0; i < 188; i++) begin
                    T2MI_DATA = 8'(i); T2MI_ENA = 1; T2MI_PSYNC = (i == 0);
                    tick();
                end
                T2MI_ENA = 0; T2MI_PSYNC = 0;
                n_vec++;
                if (T2MI_GRANT !== 1'b0) begin n_err++; $display("FAIL fair_release%0d got 1 want 0", k); end
            end
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset_abort();
        T2MI_REQ = 1;
        tick();
        T2MI_REQ = 0;
        for (int i = 0; i < 60; i++) begin
            T2MI_DATA = 8'(i + 1); T2MI_ENA = 1; T2MI_PSYNC = (i == 0);
            tick();
        end
        RST = 0;
        #1;
        n_vec++;
        if ({DATA_OUT, ENA_OUT, PSYNC_OUT, T2MI_GRANT, state_mon} !== 14'd0) begin
            n_err++; $display("FAIL async_reset got %h want 0",
                {DATA_OUT, ENA_OUT, PSYNC_OUT, T2MI_GRANT, state_mon});
        end
        idle_inputs();
        tick();
        RST = 1;
        tick();
    endtask

`ifdef TS_NULL_PACKET_EN
    task automatic test_null_packet();
        int n;
        logic [7:0] exp_b;
        idle_inputs();
        RST = 0;
        tick();
        RST = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (ENA_OUT !== 1'b1 && n < 2000);
        n_vec++;
        if (n !== 1026) begin n_err++; $display("FAIL null_start got %0d want 1026", n); end
        for (int i = 0; i < 188; i++) begin
            exp_b = (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF;
            if (i != 0) tick();
            n_vec++;
            if (DATA_OUT !== exp_b || ENA_OUT !== 1'b1 || PSYNC_OUT !== (i == 0)) begin
                n_err++; $display("FAIL null_byte%0d got %h/%0b/%0b want %h/1/%0b",
                    i, DATA_OUT, ENA_OUT, PSYNC_OUT, exp_b, (i == 0));
            end
        end
        tick();
        n_vec++;
        if (ENA_OUT !== 1'b0) begin n_err++; $display("FAIL null_end got 1 want 0"); end
        n = 0;
        do begin
            tick();
            n++;
        end while (ENA_OUT !== 1'b1 && n < 2000);
        repeat (59) tick();
        RST = 0;
        #1;
        n_vec++;
        if ({DATA_OUT, ENA_OUT, PSYNC_OUT, state_mon} !== 13'd0) begin
            n_err++; $display("FAIL null_reset got %h want 0", {DATA_OUT, ENA_OUT, PSYNC_OUT, state_mon});
        end
        tick();
        RST = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_table();
        test_ungranted();
        test_t2mi_packet();
        test_sync_error();
        test_watchdog();
        test_fairness();
        test_reset_abort();
`ifdef TS_NULL_PACKET_EN
        test_null_packet();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
